// File: rtl/rd_arb_pkg.sv
// ============================================================================
// rd_arb_pkg : read-type codes, arbiter state encoding, beat-count helpers
// Revision: 1.0
// ============================================================================
`include "definitions.svh"
`default_nettype none
package rd_arb_pkg;

  localparam logic [2:0] RD_TYPE_BYTE = 3'd0;
  localparam logic [2:0] RD_TYPE_HALF = 3'd1;
  localparam logic [2:0] RD_TYPE_WORD = 3'd2;
  localparam logic [2:0] RD_TYPE_LINE = 3'd4;

  localparam int LINE_WORD_NUM = `LINE_WORD_NUM;
  // One spare bit so a saturated count can never look like a legal burst length.
  localparam int BEAT_W = $clog2(LINE_WORD_NUM + 1) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  function automatic logic [BEAT_W-1:0] exp_beats(input logic [2:0] t);
    return (t == RD_TYPE_LINE) ? BEAT_W'(LINE_WORD_NUM) : BEAT_W'(1);
  endfunction

  function automatic logic type_ok(input logic [2:0] t);
    return (t == RD_TYPE_BYTE) || (t == RD_TYPE_HALF) ||
           (t == RD_TYPE_WORD) || (t == RD_TYPE_LINE);
  endfunction

endpackage
`default_nettype wire

// File: rtl/definitions.svh
// ============================================================================
// definitions.svh : build-wide constants for the cache/bridge read path
// Revision: 1.0
// ============================================================================
`default_nettype none
`ifndef DEFINITIONS_SVH
`define DEFINITIONS_SVH
`define LINE_WORD_NUM 4
`endif
`default_nettype wire

// File: rtl/rd_port_arbiter_rr_picker.sv
// ============================================================================
// rr_picker : combinational round-robin scan starting at rr_ptr
// Revision: 1.0
// ============================================================================
`default_nettype none
module rr_picker #(
  parameter int NUM_REQ = 3,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   idx,
  output logic               any_valid
);

  int cand;

  always_comb begin
    grant     = '0;
    idx       = '0;
    any_valid = 1'b0;
    cand      = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      // rr_ptr < NUM_REQ always, so one subtraction is enough to wrap.
      cand = int'(rr_ptr) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!any_valid && req[IDX_W'(cand)]) begin
        any_valid          = 1'b1;
        idx                = IDX_W'(cand);
        grant[IDX_W'(cand)] = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/rd_port_arbiter.sv
// ============================================================================
// rd_port_arbiter : one-outstanding round-robin share of the bridge read port
// Optional wait counters built only with RD_ARB_PERF_EN.   Revision: 1.0
// ============================================================================
`default_nettype none
module rd_port_arbiter
  import rd_arb_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [3*NUM_REQ-1:0]  req_type,
  input  logic [32*NUM_REQ-1:0] req_addr,
  output logic [NUM_REQ-1:0]    req_rdy,
  output logic [NUM_REQ-1:0]    req_ret_valid,
  output logic [NUM_REQ-1:0]    req_ret_last,
  output logic [31:0]           req_ret_data,
  output logic                  rd_req,
  output logic [2:0]            rd_type,
  output logic [31:0]           rd_addr,
  input  logic                  rd_rdy,
  input  logic                  ret_valid,
  input  logic                  ret_last,
  input  logic [31:0]           ret_data,
  output logic                  proto_err,
  output logic [32*NUM_REQ-1:0] perf_wait_cnt
);

  arb_state_t        state_q, state_d;
  logic              rd_req_q, rd_req_d;
  logic [2:0]        rd_type_q, rd_type_d;
  logic [31:0]       rd_addr_q, rd_addr_d;
  logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]  grant_idx_q, grant_idx_d;
  logic [BEAT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic              proto_err_q, proto_err_d;

  logic [NUM_REQ-1:0] pick_grant;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_any;
  logic [BEAT_W-1:0]  beat_inc;

  logic [2:0]  type_a [NUM_REQ];
  logic [31:0] addr_a [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign type_a[gi] = req_type[3*gi +: 3];
    assign addr_a[gi] = req_addr[32*gi +: 32];
  end : g_unpack

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_picker (
    .req       (req_valid),
    .rr_ptr    (rr_ptr_q),
    .grant     (pick_grant),
    .idx       (pick_idx),
    .any_valid (pick_any)
  );

  assign beat_inc = (beat_cnt_q == '1) ? beat_cnt_q : beat_cnt_q + BEAT_W'(1);

  always_comb begin
    state_d       = state_q;
    rd_req_d      = rd_req_q;
    rd_type_d     = rd_type_q;
    rd_addr_d     = rd_addr_q;
    rr_ptr_d      = rr_ptr_q;
    grant_idx_d   = grant_idx_q;
    beat_cnt_d    = beat_cnt_q;
    proto_err_d   = proto_err_q;
    req_rdy       = '0;
    req_ret_valid = '0;
    req_ret_last  = '0;
    case (state_q)
      IDLE: begin
        if (ret_valid) proto_err_d = 1'b1;
        if (pick_any) begin
          req_rdy     = pick_grant;
          grant_idx_d = pick_idx;
          rd_type_d   = type_a[pick_idx];
          rd_addr_d   = addr_a[pick_idx];
          rd_req_d    = 1'b1;
          state_d     = REQ;
          // Unsupported types are still forwarded; only flagged.
          if (!type_ok(type_a[pick_idx])) proto_err_d = 1'b1;
        end
      end
      REQ: begin
        if (ret_valid) proto_err_d = 1'b1;
        if (rd_rdy) begin
          rd_req_d   = 1'b0;
          beat_cnt_d = '0;
          state_d    = RESP;
        end
      end
      RESP: begin
        if (ret_valid) begin
          req_ret_valid[grant_idx_q] = 1'b1;
          beat_cnt_d                 = beat_inc;
          if (ret_last) begin
            req_ret_last[grant_idx_q] = 1'b1;
            if (beat_inc != exp_beats(rd_type_q)) proto_err_d = 1'b1;
            state_d  = IDLE;
            rr_ptr_d = (grant_idx_q == IDX_W'(NUM_REQ - 1)) ? '0
                                                              : grant_idx_q + IDX_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      rd_req_q    <= 1'b0;
      rd_type_q   <= '0;
      rd_addr_q   <= '0;
      rr_ptr_q    <= '0;
      grant_idx_q <= '0;
      beat_cnt_q  <= '0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_req_q    <= rd_req_d;
      rd_type_q   <= rd_type_d;
      rd_addr_q   <= rd_addr_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_idx_q <= grant_idx_d;
      beat_cnt_q  <= beat_cnt_d;
      proto_err_q <= proto_err_d;
    end
  end

  assign rd_req       = rd_req_q;
  assign rd_type      = rd_type_q;
  assign rd_addr      = rd_addr_q;
  assign proto_err    = proto_err_q;
  assign req_ret_data = ret_data;

`ifdef RD_ARB_PERF_EN
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_perf
    logic [31:0] cnt_q, cnt_d;

    always_comb begin
      cnt_d = cnt_q;
      if (req_valid[gi] && !req_rdy[gi] && (cnt_q != 32'hFFFF_FFFF)) cnt_d = cnt_q + 32'd1;
    end

    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) cnt_q <= '0;
      else         cnt_q <= cnt_d;
    end

    assign perf_wait_cnt[32*gi +: 32] = cnt_q;
  end : g_perf
`else
  assign perf_wait_cnt = '0;
`endif

endmodule
`default_nettype wire
